// File: rtl/cmd_loader_pkg.sv
// Shared types and width helpers for the command-memory loader.
package cmd_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    function automatic int words_per_cmd(input int cmd_width, input int in_width);
        return cmd_width / in_width;
    endfunction

    // A command must be built from a whole number of host words.
    function automatic bit cmd_width_ok(input int cmd_width, input int in_width);
        return (in_width > 0) && (cmd_width >= in_width) && ((cmd_width % in_width) == 0);
    endfunction

endpackage

// File: rtl/cmd_packer.sv
// Packs host words little-endian into one command; cmd_valid pulses combinationally
// with the final word so the caller can register the full command on that edge.
module cmd_packer
    import cmd_loader_pkg::*;
#(
    parameter int CMD_WIDTH = 128,
    parameter int IN_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 clear,
    input  logic                 word_valid,
    input  logic [IN_WIDTH-1:0]  word,
    output logic                 cmd_valid,
    output logic [CMD_WIDTH-1:0] cmd_data
);

    localparam int WPC   = words_per_cmd(CMD_WIDTH, IN_WIDTH);
    localparam int CNT_W = (WPC > 1) ? $clog2(WPC) : 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WPC - 1);

    logic [CNT_W-1:0]     word_cnt;
    logic [CMD_WIDTH-1:0] assembly;

    always_ff @(posedge clk) begin
        if (clear) begin
            word_cnt <= '0;
            assembly <= '0;
        end else if (word_valid) begin
            assembly[word_cnt*IN_WIDTH +: IN_WIDTH] <= word;
            word_cnt <= (word_cnt == LAST_WORD) ? '0 : word_cnt + CNT_W'(1);
        end
    end

    assign cmd_valid = word_valid && !clear && (word_cnt == LAST_WORD);

    // The last word bypasses the assembly register so the write lands one cycle after it.
    always_comb begin
        cmd_data = assembly;
        cmd_data[(WPC-1)*IN_WIDTH +: IN_WIDTH] = word;
    end

endmodule

// File: rtl/cmd_loader.sv
// Command-memory write front end: packs host words and writes commands at base+idx.
// Optional running checksum of accepted words enabled by CMD_LOADER_CSUM_EN.
module cmd_loader
    import cmd_loader_pkg::*;
#(
    parameter int CMD_WIDTH  = 128,
    parameter int ADDR_WIDTH = 8,
    parameter int IN_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   num_cmds,
    input  logic [IN_WIDTH-1:0]   in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  write_enable,
    output logic [ADDR_WIDTH-1:0] write_address,
    output logic [CMD_WIDTH-1:0]  cmd_in,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [IN_WIDTH-1:0]   csum
);

    localparam logic [ADDR_WIDTH:0] MAX_CMDS = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE_CMD  = (ADDR_WIDTH+1)'(1);

    if (!cmd_width_ok(CMD_WIDTH, IN_WIDTH)) begin : g_width_check
        $error("cmd_loader: CMD_WIDTH must be an integer multiple of IN_WIDTH");
    end

    state_t                state;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH:0]   num_q;
    logic [ADDR_WIDTH:0]   cmd_idx;
    logic                  accept;
    logic                  start_load;
    logic                  pack_clear;
    logic                  cmd_valid;
    logic [CMD_WIDTH-1:0]  cmd_data;

    // abort wins over a word arriving in the same cycle, so that word is never packed.
    assign accept     = in_ready && in_valid && !abort;
    assign start_load = (state == IDLE) && start && !abort
                        && (num_cmds != '0) && (num_cmds <= MAX_CMDS);
    assign pack_clear = reset || abort || start_load;

    cmd_packer #(
        .CMD_WIDTH (CMD_WIDTH),
        .IN_WIDTH  (IN_WIDTH)
    ) u_packer (
        .clk        (clk),
        .clear      (pack_clear),
        .word_valid (accept),
        .word       (in_data),
        .cmd_valid  (cmd_valid),
        .cmd_data   (cmd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            in_ready      <= 1'b0;
            write_enable  <= 1'b0;
            write_address <= '0;
            cmd_in        <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            base_q        <= '0;
            num_q         <= '0;
            cmd_idx       <= '0;
        end else begin
            write_enable <= 1'b0;
            done         <= 1'b0;
            if (abort) begin
                state    <= IDLE;
                in_ready <= 1'b0;
                busy     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (num_cmds == '0) begin
                                done <= 1'b1;
                            end else if (num_cmds > MAX_CMDS) begin
                                err <= 1'b1;
                            end else begin
                                base_q   <= base_addr;
                                num_q    <= num_cmds;
                                cmd_idx  <= '0;
                                err      <= 1'b0;
                                state    <= LOAD;
                                in_ready <= 1'b1;
                                busy     <= 1'b1;
                            end
                        end
                    end
                    LOAD: begin
                        if (cmd_valid) begin
                            write_enable  <= 1'b1;
                            write_address <= base_q + cmd_idx[ADDR_WIDTH-1:0];
                            cmd_in        <= cmd_data;
                            cmd_idx       <= cmd_idx + ONE_CMD;
                            if ((cmd_idx + ONE_CMD) == num_q) begin
                                state    <= FLUSH;
                                in_ready <= 1'b0;
                            end
                        end
                    end
                    FLUSH: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                    default: begin
                        state    <= IDLE;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef CMD_LOADER_CSUM_EN
    always_ff @(posedge clk) begin
        if (reset || start_load) begin
            csum <= '0;
        end else if (accept) begin
            csum <= csum + in_data;
        end
    end
`else
    assign csum = '0;
`endif

endmodule

// File: tb/tb_cmd_loader.sv
// Randomized scoreboard bench for cmd_loader: expected writes/dones are queued by
// the stimulus and popped by a negedge monitor.
module tb_cmd_loader;

    localparam int CW  = 128;
    localparam int AW  = 8;
    localparam int IW  = 32;
    localparam int WPC = CW / IW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   num_cmds = '0;
    logic [IW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          write_enable;
    logic [AW-1:0] write_address;
    logic [CW-1:0] cmd_in;
    logic          busy;
    logic          done;
    logic          err;
    logic [IW-1:0] csum;

    cmd_loader #(.CMD_WIDTH(CW), .ADDR_WIDTH(AW), .IN_WIDTH(IW)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .base_addr     (base_addr),
        .num_cmds      (num_cmds),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .write_enable  (write_enable),
        .write_address (write_address),
        .cmd_in        (cmd_in),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .csum          (csum)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [CW-1:0] data;
        int            cyc;
    } wr_t;

    int            checks = 0;
    int            errors = 0;
    int            ncyc = 0;
    wr_t           wr_q[$];
    int            done_q[$];
    logic [IW-1:0] m_csum = '0;

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [IW-1:0] exp_csum();
`ifdef CMD_LOADER_CSUM_EN
        return m_csum;
`else
        return '0;
`endif
    endfunction

    // Monitor: every write/done must match the oldest queued expectation, including its cycle.
    always @(negedge clk) begin
        wr_t e;
        int  dc;
        ncyc++;
        if (write_enable) begin
            if (wr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got write at %0h, required none", write_address);
            end else begin
                e = wr_q.pop_front();
                chk("write_addr", CW'(write_address), CW'(e.addr));
                chk("write_data", cmd_in, e.data);
                chk("write_cycle", CW'(ncyc), CW'(e.cyc));
            end
        end
        if (done) begin
            if (done_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done at cycle %0d, required none", ncyc);
            end else begin
                dc = done_q.pop_front();
                chk("done_cycle", CW'(ncyc), CW'(dc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [AW-1:0] b, input logic [AW:0] n);
        base_addr = b;
        num_cmds  = n;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int b;
        b = budget;
        while ((wr_q.size() != 0 || done_q.size() != 0) && b > 0) begin
            tick();
            b--;
        end
        tick();
        tick();
        checks++;
        if (wr_q.size() != 0 || done_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d writes and %0d dones pending, required 0",
                     wr_q.size(), done_q.size());
        end
    endtask

    // kill_mode: 0 = run to completion, 1 = abort before word kill_at, 2 = reset before word kill_at
    task automatic run_load(input logic [AW-1:0] base, input int n, input int gap,
                            input int kill_at, input int kill_mode, input bit seq_data,
                            input bit poke_start);
        logic [CW-1:0] cmd;
        logic [IW-1:0] w;
        wr_t           e;
        int            total, budget, c_at, last_cyc;
        bit            v, acc, tgl;
        total    = n * WPC;
        budget   = total * 8 + 100;
        cmd      = '0;
        tgl      = 1'b0;
        last_cyc = 0;
        c_at     = 0;
        pulse_start(base, (AW+1)'(n));
        m_csum = '0;
        chk("busy_after_start", CW'(busy), CW'(1));
        for (int k = 0; k < total; k++) begin
            if (kill_mode != 0 && k == kill_at) break;
            w   = seq_data ? IW'(k + 1) : IW'($urandom);
            acc = 1'b0;
            while (!acc && budget > 0) begin
                tgl       = ~tgl;
                v         = (gap == 0) ? 1'b1 : (gap == 1) ? tgl : 1'($urandom_range(0, 1));
                start     = poke_start && (k == WPC + 1);
                base_addr = base ^ AW'(8'hA5);
                in_valid  = v;
                in_data   = v ? w : IW'($urandom);
                acc       = v && in_ready;
                c_at      = ncyc;
                tick();
                budget--;
            end
            start = 1'b0;
            if (!acc) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: word %0d got no acceptance, required acceptance", k);
                break;
            end
            m_csum = m_csum + w;
            cmd[(k % WPC)*IW +: IW] = w;
            if ((k % WPC) == WPC - 1) begin
                e.addr   = base + AW'(k / WPC);
                e.data   = cmd;
                e.cyc    = c_at + 2;
                last_cyc = c_at + 2;
                wr_q.push_back(e);
            end
        end
        in_valid = 1'b0;
        if (kill_mode == 0) begin
            done_q.push_back(last_cyc + 1);
        end else if (kill_mode == 1) begin
            abort = 1'b1;
            tick();
            abort = 1'b0;
        end else begin
            reset = 1'b1;
            tick();
            reset  = 1'b0;
            m_csum = '0;
            chk("rst_cmd_in", cmd_in, '0);
            chk("rst_write_address", CW'(write_address), '0);
        end
        wait_drain(64);
        chk("busy_idle", CW'(busy), '0);
        chk("in_ready_idle", CW'(in_ready), '0);
        chk("csum", CW'(csum), CW'(exp_csum()));
        chk("err_clear", CW'(err), '0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        logic [IW-1:0] basic_csum;
        reset = 1'b1;
        tick();
        tick();
        chk("rst_in_ready", CW'(in_ready), '0);
        chk("rst_write_enable", CW'(write_enable), '0);
        chk("rst_write_address", CW'(write_address), '0);
        chk("rst_cmd_in", cmd_in, '0);
        chk("rst_busy", CW'(busy), '0);
        chk("rst_done", CW'(done), '0);
        chk("rst_err", CW'(err), '0);
        chk("rst_csum", CW'(csum), '0);
        reset = 1'b0;
        tick();

        // Basic load: words 1..8 at base 0x10
        run_load(8'h10, 2, 0, 0, 0, 1'b1, 1'b0);
`ifdef CMD_LOADER_CSUM_EN
        basic_csum = 32'h24;
`else
        basic_csum = 32'h0;
`endif
        chk("csum_basic", CW'(csum), CW'(basic_csum));

        // Address wrap past the top
        run_load(8'hFF, 2, 0, 0, 0, 1'b0, 1'b0);

        // in_valid toggled every other cycle
        run_load(8'h10, 2, 1, 0, 0, 1'b1, 1'b0);

        // num_cmds = 0: done next cycle, no writes
        c = ncyc;
        pulse_start(8'h22, '0);
        done_q.push_back(c + 2);
        wait_drain(16);
        chk("zero_busy", CW'(busy), '0);

        // num_cmds = 257: err only
        pulse_start(8'h20, (AW+1)'(257));
        tick();
        tick();
        chk("over_err", CW'(err), CW'(1));
        chk("over_busy", CW'(busy), '0);

        // A valid start clears err (checked inside run_load)
        run_load(8'h44, 1, 0, 0, 0, 1'b0, 1'b0);

        // err again, then reset clears it
        pulse_start(8'h20, (AW+1)'(300));
        tick();
        chk("over_err2", CW'(err), CW'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("reset_clears_err", CW'(err), '0);
        tick();

        // Full memory
        run_load(8'h00, 256, 0, 0, 0, 1'b0, 1'b0);

        // Abort after 6 of 8 words, then a clean load
        run_load(8'h30, 2, 0, 6, 1, 1'b1, 1'b0);
        run_load(8'h30, 2, 0, 0, 0, 1'b1, 1'b0);

        // Reset mid-command, then a clean load
        run_load(8'h50, 2, 0, 6, 2, 1'b0, 1'b0);
        run_load(8'h60, 3, 0, 0, 0, 1'b0, 1'b0);

        // Random loads with random gaps and a stray start while busy
        for (int i = 0; i < 8; i++) begin
            run_load(AW'($urandom), $urandom_range(1, 5), 2, 0, 0, 1'b0, 1'b1);
        end

        wait_drain(16);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmd_loader.md
# cmd_loader

Write-side front end for the command memory. Accepts a narrow stream of host words over a valid/ready handshake, packs each group of CMD_WIDTH/IN_WIDTH words into one command, and drives the memory write port (write_enable, write_address, cmd_in) at sequential addresses starting from a programmed base. It sits between the host/config interconnect and the command memory's write port, and reports completion and errors back to the host.

## Interface
- CMD_WIDTH, 128: command width in bits; must be an integer multiple of IN_WIDTH.
- ADDR_WIDTH, 8: command memory address width.
- IN_WIDTH, 32: host word width.
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; latches base_addr and num_cmds and begins a load.
- abort  in  1  cancels an active load.
- base_addr  in  ADDR_WIDTH  first command address.
- num_cmds  in  ADDR_WIDTH+1  number of commands to load (0 to 2^ADDR_WIDTH).
- in_data  in  IN_WIDTH  host word.
- in_valid  in  1  host word valid.
- in_ready  out  1  loader accepts a word this cycle.
- write_enable  out  1  memory write strobe.
- write_address  out  ADDR_WIDTH  memory write address.
- cmd_in  out  CMD_WIDTH  packed command to memory.
- busy  out  1  load in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky error flag.
- csum  out  IN_WIDTH  running sum of accepted words (see Configuration).

## Operation
- WPC = CMD_WIDTH/IN_WIDTH words per command.
- States: IDLE, LOAD, FLUSH.
- IDLE:
  - in_ready=0.
  - start with num_cmds in 1..2^ADDR_WIDTH: latch inputs, clear err/csum/word and command counters, go to LOAD.
  - start with num_cmds==0: pulse done next cycle; no writes; stay IDLE.
  - start with num_cmds>2^ADDR_WIDTH: set err; no writes; no done.
- LOAD:
  - in_ready=1. A word is accepted when in_valid&&in_ready.
  - Packing is little-endian: the k-th word of a command occupies bits [k*IN_WIDTH +: IN_WIDTH].
  - On acceptance of word WPC-1, register cmd_in, write_address=base+cmd_idx (mod 2^ADDR_WIDTH, wraps past the top), and write_enable=1 for exactly one cycle. Then increment cmd_idx and clear the word counter.
  - When the final word of command num_cmds-1 is accepted, go to FLUSH.
- FLUSH:
  - in_ready=0.
  - Final write_enable is high this cycle; done pulses the following cycle as the FSM returns to IDLE.
- start while busy is ignored, with no effect on the load.
- abort (any state): return to IDLE next cycle. Discard the partial command; no write; no done; err unchanged. abort has priority over start and over the write in the same cycle.
- reset mid-load: same as abort, and additionally clears err and csum.

## Timing
- Reset values: in_ready=0, write_enable=0, write_address=0, cmd_in=0, busy=0, done=0, err=0, csum=0.
- busy is high from the cycle after start through the FLUSH cycle.
- Latency: write_enable asserts 1 cycle after the last word of a command is accepted.
- Throughput: one word per cycle; back-to-back commands write every WPC cycles with no bubble.
- in_valid gaps stall packing without loss.

## Configuration
- CMD_LOADER_CSUM_EN defined:
  - csum = modulo-2^IN_WIDTH sum of all words accepted since the last start.
  - Updates the cycle after each acceptance.
  - Final value is stable when done pulses.
- Not defined: csum is tied to 0 and the adder is removed; all other behaviour is identical.

## Structure
- Package cmd_loader_pkg holds:
  - the state enum (IDLE/LOAD/FLUSH);
  - a words_per_cmd(CMD_WIDTH, IN_WIDTH) constant function;
  - an elaboration check that CMD_WIDTH % IN_WIDTH == 0.
- Sub-module cmd_packer:
  - word counter and assembly register;
  - asserts a cmd_valid pulse with the packed command;
  - clear input driven by start, abort and reset.
- cmd_loader holds the FSM, address/command counters, error flag and checksum.

## Test plan
- Basic load: base=0x10, num_cmds=2, 8 words 0x1..0x8 → writes at 0x10 = {0x4,0x3,0x2,0x1} and 0x11 = {0x8,0x7,0x6,0x5}; done 1 cycle after the second write_enable; with the macro, csum=0x24.
- Wrap: base=0xFF, num_cmds=2 → writes at 0xFF then 0x00.
- Backpressure gaps: in_valid toggled every other cycle → identical write contents and addresses; no extra write_enable pulses.
- Boundary counts:
  - num_cmds=0 → done next cycle, no writes.
  - num_cmds=257 (ADDR_WIDTH=8) → err=1, no writes, no done.
  - num_cmds=256 → 256 writes, done.
- Abort after 6 of 8 words → one write at base only; busy drops; no done; a following start loads cleanly from a zero word count.
- reset asserted mid-command, then a new start → no stale partial data in the first written command; err=0, csum=0.
